// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with stall hold and branch flush
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FETCH_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [25:0] ext_a,
    output logic [2:0]  ext_sel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] flush_target;
    logic [31:0] branch_pc;

    // pc keeps the address of the in-flight request while FLUSH waits for the
    // abandoned ack, so the request address stays on the old word; the
    // redirect address waits in flush_target until that ack arrives.
    assign mem_addr  = pc;
    assign branch_pc = {branch_target[31:2], 2'b00};
    assign ext_a     = instr[31:6];
    assign ext_sel   = instr[5:3];

    // Fetch sequencing, request generation and instruction capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= RESET_PC & ~32'd3;
            flush_target <= 32'd0;
            mem_req      <= 1'b0;
            instr        <= 32'd0;
            pc_out       <= 32'd0;
            instr_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_en) begin
                        pc          <= branch_pc;
                        instr_valid <= 1'b0;
                    end
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
                FETCH: begin
                    if (branch_en) begin
                        instr_valid <= 1'b0;
                        if (mem_ack) begin
                            pc    <= branch_pc;
                            state <= FETCH;
                        end else begin
                            flush_target <= branch_pc;
                            state        <= FLUSH;
                        end
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        instr       <= mem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'(FETCH_STEP);
                        if (stall) begin
                            state   <= HOLD;
                            mem_req <= 1'b0;
                        end else begin
                            state   <= FETCH;
                            mem_req <= 1'b1;
                        end
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_en) begin
                        pc          <= branch_pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                        mem_req     <= 1'b1;
                    end else if (!stall) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (branch_en) begin
                        if (mem_ack) begin
                            pc    <= branch_pc;
                            state <= FETCH;
                        end else begin
                            flush_target <= branch_pc;
                        end
                    end else if (mem_ack) begin
                        pc    <= flush_target;
                        state <= FETCH;
                    end
                    mem_req <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized model-based bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_ack;
    logic        stall;
    logic        branch_en;
    logic [31:0] mem_rdata;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [25:0] ext_a;
    logic [2:0]  ext_sel;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc_out;
    logic [25:0] w_ext_a;
    logic [2:0]  w_ext_sel;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .ext_a         (ext_a),
        .ext_sel       (ext_sel)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFF), .FETCH_STEP(4)) u_wrap (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req       (w_req),
        .mem_addr      (w_addr),
        .mem_ack       (1'b1),
        .mem_rdata     (32'h0),
        .stall         (1'b0),
        .branch_en     (1'b0),
        .branch_target (32'h0),
        .instr         (w_instr),
        .instr_valid   (w_valid),
        .pc_out        (w_pc_out),
        .ext_a         (w_ext_a),
        .ext_sel       (w_ext_sel)
    );

    // Reference model: "requesting" means a read is on the bus; "discard"
    // means that read was overtaken by a redirect and its data is thrown away.
    bit          m_started;
    bit          m_requesting;
    bit          m_discard;
    logic [31:0] m_next_addr;
    logic [31:0] m_redirect;
    logic [31:0] m_instr;
    logic [31:0] m_pc_out;
    bit          m_valid;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_started    = 0;
            m_requesting = 0;
            m_discard    = 0;
            m_next_addr  = 32'h0;
            m_redirect   = 32'h0;
            m_instr      = 32'h0;
            m_pc_out     = 32'h0;
            m_valid      = 0;
        end else if (!m_started) begin
            m_started    = 1;
            m_requesting = 1;
            if (branch_en) begin
                m_next_addr = branch_target & ~32'd3;
                m_valid     = 0;
            end
        end else if (!m_requesting) begin
            if (branch_en) begin
                m_next_addr  = branch_target & ~32'd3;
                m_valid      = 0;
                m_requesting = 1;
            end else if (!stall) begin
                m_requesting = 1;
            end
        end else if (branch_en) begin
            m_valid = 0;
            if (mem_ack) begin
                m_next_addr = branch_target & ~32'd3;
                m_discard   = 0;
            end else begin
                m_redirect = branch_target & ~32'd3;
                m_discard  = 1;
            end
        end else if (m_discard) begin
            if (mem_ack) begin
                m_next_addr = m_redirect;
                m_discard   = 0;
            end
        end else if (mem_ack) begin
            m_instr     = mem_rdata;
            m_pc_out    = m_next_addr;
            m_valid     = 1;
            m_next_addr = m_next_addr + 32'd4;
            if (stall) m_requesting = 0;
        end else begin
            m_valid = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic compare_model();
        chk("mem_req", 32'(mem_req), 32'(m_requesting));
        chk("mem_addr", mem_addr, m_next_addr);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        chk("pc_out", pc_out, m_pc_out);
        chk("ext_a", 32'(ext_a), 32'(m_instr >> 6));
        chk("ext_sel", 32'(ext_sel), 32'((m_instr >> 3) & 32'h7));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_ack       = 1'b0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        mem_rdata     = 32'h0;
        branch_target = 32'h0;
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);

        // Back-to-back stream with ack tied high
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h9BB2_B2CA;
        tick();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        chk("first_valid", 32'(instr_valid), 32'd0);
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("s_instr", instr, 32'h9BB2_B2CA);
        chk("s_valid", 32'(instr_valid), 32'd1);
        chk("s_pc_out", pc_out, 32'h0);
        chk("s_ext_a", 32'(ext_a), 32'h026E_CACB);
        chk("s_ext_sel", 32'(ext_sel), 32'd1);
        chk("s_addr4", mem_addr, 32'h4);
        chk("wrap_addr1", w_addr, 32'h0);
        tick();
        chk("s_pc_out4", pc_out, 32'h4);
        chk("s_addr8", mem_addr, 32'h8);
        chk("wrap_addr2", w_addr, 32'h4);

        // Ack delayed three cycles
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_addr", mem_addr, 32'h8);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        chk("late_valid", 32'(instr_valid), 32'd1);
        chk("late_pc_out", pc_out, 32'h8);
        chk("late_instr", instr, 32'h1234_5678);

        // Stall for five cycles after a delivery
        stall     = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        tick();
        chk("stall_req", 32'(mem_req), 32'd0);
        chk("stall_pc_out", pc_out, 32'hC);
        mem_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_req", 32'(mem_req), 32'd0);
            chk("hold_instr", instr, 32'hAAAA_5555);
            chk("hold_pc_out", pc_out, 32'hC);
        end
        stall = 1'b0;
        tick();
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_addr", mem_addr, 32'h10);
        tick();
        chk("resume_pc_out", pc_out, 32'h10);

        // Redirect while a request is pending, ack two cycles later
        mem_ack       = 1'b0;
        branch_en     = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        chk("flush_req", 32'(mem_req), 32'd1);
        chk("flush_addr", mem_addr, 32'h14);
        chk("flush_valid", 32'(instr_valid), 32'd0);
        branch_en = 1'b0;
        tick();
        chk("flush_addr2", mem_addr, 32'h14);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("target_addr", mem_addr, 32'h100);
        chk("discard_valid", 32'(instr_valid), 32'd0);
        mem_rdata = 32'h0000_0F00;
        tick();
        chk("target_valid", 32'(instr_valid), 32'd1);
        chk("target_pc_out", pc_out, 32'h100);

        // One-cycle reset during an acked fetch
        reset_n = 1'b0;
        tick();
        chk("mrst_req", 32'(mem_req), 32'd0);
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_instr", instr, 32'd0);
        chk("mrst_pc_out", pc_out, 32'd0);
        chk("mrst_addr", mem_addr, 32'd0);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mem_ack       = ($urandom_range(0, 9) < 7);
            stall         = ($urandom_range(0, 9) < 2);
            branch_en     = ($urandom_range(0, 19) == 0);
            branch_target = $urandom;
            mem_rdata     = $urandom;
            reset_n       = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
